// File: rtl/heartbeat_anim_if.sv
// Board-side bundle for the heartbeat animation engine: control inputs, display pins,
// step strobe and the current animation mode for observation.
interface heartbeat_anim_if #(
    parameter int N_DIGITS = 4
);
    // en is a level qualifier, not a handshake: while high every clock counts toward the
    // next step; frame_tick is a one-cycle strobe with no back-pressure.
    logic                en;
    logic [1:0]          mode;
    logic [N_DIGITS-1:0] an;
    logic [7:0]          sseg;
    logic                frame_tick;
    logic [1:0]          mode_state;

    modport master (
        output en, mode,
        input  an, sseg, frame_tick, mode_state
    );

    modport slave (
        input  en, mode,
        output an, sseg, frame_tick, mode_state
    );
endinterface

// File: rtl/heartbeat_anim.sv
// Multiplexed common-anode seven-segment animation engine: heartbeat, sweep and bounce
// patterns paced by a step timer, with a free-running digit scan.
module heartbeat_anim #(
    parameter int N_DIGITS    = 4,
    parameter int STEP_TICKS  = 10_000_000,
    parameter int REFRESH_DIV = 50_000
) (
    input logic             clk,
    input logic             reset,
    heartbeat_anim_if.slave bus
);
    typedef enum logic [1:0] {
        HEARTBEAT = 2'd0,
        SWEEP     = 2'd1,
        BOUNCE    = 2'd2,
        BLANK     = 2'd3
    } mode_t;

    localparam int SW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TW   = $clog2(STEP_TICKS);
    localparam int HALF = N_DIGITS / 2;

    localparam logic [SW-1:0] LAST  = SW'(N_DIGITS - 1);
    localparam logic [SW-1:0] HLAST = SW'(HALF - 1);
    localparam logic          UP    = 1'b0;
    localparam logic          DOWN  = 1'b1;

    logic [RW-1:0]       ref_cnt;
    logic [SW-1:0]       sel;
    logic [TW-1:0]       step_cnt;
    logic [SW-1:0]       pos, next_pos;
    logic                dir, next_dir;
    mode_t               mode_q, mode_in;
    logic [N_DIGITS-1:0] an_q;
    logic [7:0]          sseg_q;
    logic                frame_tick_q;

    assign mode_in        = mode_t'(bus.mode);
    assign bus.an         = an_q;
    assign bus.sseg       = sseg_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.mode_state = mode_q;

    // BLANK has no start position of its own, so entering it keeps whatever was showing.
    function automatic logic [SW-1:0] start_pos(input mode_t m, input logic [SW-1:0] cur);
        case (m)
            HEARTBEAT:     start_pos = '0;
            SWEEP, BOUNCE: start_pos = LAST;
            default:       start_pos = cur;
        endcase
    endfunction

    function automatic logic start_dir(input mode_t m, input logic cur);
        case (m)
            HEARTBEAT:     start_dir = UP;
            SWEEP, BOUNCE: start_dir = DOWN;
            default:       start_dir = cur;
        endcase
    endfunction

    function automatic logic [7:0] pattern(input logic [SW-1:0] s, input logic [SW-1:0] p,
                                           input mode_t m);
        int si;
        int pi;
        si      = int'(s);
        pi      = int'(p);
        pattern = 8'hFF;
        case (m)
            HEARTBEAT: begin
                if (si == HALF + pi)          pattern = 8'hCF;
                else if (si == HALF - 1 - pi) pattern = 8'hF9;
            end
            SWEEP:   if (s == p) pattern = 8'hBF;
            BOUNCE:  if (s == p) pattern = 8'hA3;
            default: pattern = 8'hFF;
        endcase
    endfunction

    // Position advance for one animation step; both ping-pong modes turn at the ends
    // without dwelling, so endpoints appear once per pass.
    always_comb begin
        next_pos = pos;
        next_dir = dir;
        case (mode_q)
            HEARTBEAT: begin
                if (HALF > 1) begin
                    if (dir == UP) begin
                        if (pos == HLAST) begin
                            next_pos = pos - SW'(1);
                            next_dir = DOWN;
                        end else begin
                            next_pos = pos + SW'(1);
                        end
                    end else if (pos == '0) begin
                        next_pos = SW'(1);
                        next_dir = UP;
                    end else begin
                        next_pos = pos - SW'(1);
                    end
                end
            end
            SWEEP: next_pos = (pos == '0) ? LAST : pos - SW'(1);
            BOUNCE: begin
                if (dir == DOWN) begin
                    if (pos == '0) begin
                        next_pos = SW'(1);
                        next_dir = UP;
                    end else begin
                        next_pos = pos - SW'(1);
                    end
                end else if (pos == LAST) begin
                    next_pos = LAST - SW'(1);
                    next_dir = DOWN;
                end else begin
                    next_pos = pos + SW'(1);
                end
            end
            default: begin
                next_pos = pos;
                next_dir = dir;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_cnt      <= '0;
            sel          <= '0;
            step_cnt     <= '0;
            mode_q       <= mode_in;
            pos          <= start_pos(mode_in, '0);
            dir          <= start_dir(mode_in, UP);
            an_q         <= '1;
            sseg_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                sel     <= (sel == LAST) ? '0 : sel + SW'(1);
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end

            an_q   <= (mode_q == BLANK) ? '1 : ~(N_DIGITS'(1) << sel);
            sseg_q <= pattern(sel, pos, mode_q);

            // A mode change wins over a coincident terminal count and ignores en.
            if (mode_in != mode_q) begin
                mode_q       <= mode_in;
                pos          <= start_pos(mode_in, pos);
                dir          <= start_dir(mode_in, dir);
                step_cnt     <= '0;
                frame_tick_q <= 1'b0;
            end else if (bus.en && step_cnt == TW'(STEP_TICKS - 1)) begin
                step_cnt     <= '0;
                pos          <= next_pos;
                dir          <= next_dir;
                frame_tick_q <= 1'b1;
            end else begin
                if (bus.en) step_cnt <= step_cnt + TW'(1);
                frame_tick_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_heartbeat_anim.sv
// Directed plus randomized bench for heartbeat_anim against a sequence-table model
// of the animation and a cycle-count model of the scan.
module tb_heartbeat_anim;
    localparam int N  = 4;
    localparam int ST = 8;
    localparam int RD = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    heartbeat_anim_if #(.N_DIGITS(N)) bus ();

    heartbeat_anim #(
        .N_DIGITS   (N),
        .STEP_TICKS (ST),
        .REFRESH_DIV(RD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Position sequences per mode, indexed by steps taken since the mode was entered.
    function automatic int seq_len(input int m);
        case (m)
            0:       return (N / 2 == 1) ? 1 : N - 2;
            1:       return N;
            default: return 2 * N - 2;
        endcase
    endfunction

    function automatic int seq_at(input int m, input int i);
        case (m)
            0:       return (i < N / 2) ? i : N - 2 - i;
            1:       return N - 1 - i;
            default: return (i < N) ? N - 1 - i : i - N + 1;
        endcase
    endfunction

    function automatic logic [7:0] glyph(input int d, input int p, input int m);
        logic [7:0] g;
        g = 8'hFF;
        case (m)
            0: begin
                if (d == N / 2 + p)          g = 8'hCF;
                else if (d == N / 2 - 1 - p) g = 8'hF9;
            end
            1:       if (d == p) g = 8'hBF;
            2:       if (d == p) g = 8'hA3;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    int           scan, phase, k, pos_m, mode_m, sel_m;
    logic [N-1:0] exp_an;
    logic [7:0]   exp_sseg;
    logic         exp_ft;
    bit           model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            exp_an   = '1;
            exp_sseg = 8'hFF;
            exp_ft   = 1'b0;
            scan     = 0;
            phase    = 0;
            k        = 0;
            mode_m   = int'(bus.mode);
            pos_m    = (mode_m == 3) ? 0 : seq_at(mode_m, 0);
            model_ok = 1'b1;
        end else begin
            sel_m = (scan / RD) % N;
            for (int d = 0; d < N; d++) exp_an[d] = (mode_m == 3) ? 1'b1 : (d != sel_m);
            exp_sseg = glyph(sel_m, pos_m, mode_m);
            scan++;
            if (int'(bus.mode) != mode_m) begin
                mode_m = int'(bus.mode);
                phase  = 0;
                k      = 0;
                if (mode_m != 3) pos_m = seq_at(mode_m, 0);
                exp_ft = 1'b0;
            end else if (bus.en) begin
                phase++;
                exp_ft = 1'b0;
                if (phase == ST) begin
                    phase  = 0;
                    exp_ft = 1'b1;
                    if (mode_m != 3) begin
                        k     = (k + 1) % seq_len(mode_m);
                        pos_m = seq_at(mode_m, k);
                    end
                end
            end else begin
                exp_ft = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("an", bus.an, exp_an);
            chk("sseg", bus.sseg, exp_sseg);
            chk("frame_tick", bus.frame_tick, exp_ft);
            chk("mode_state", bus.mode_state, mode_m);
        end
    end

    task automatic count_to_tick(input string tag, input int want);
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.frame_tick && cnt < 4 * ST);
        chk(tag, cnt, want);
    endtask

    task automatic wait_phase(input int p);
        int cnt;
        cnt = 0;
        while (!(phase == p && mode_m == int'(bus.mode)) && cnt < 10 * ST) begin
            @(negedge clk);
            cnt++;
        end
        chk("wait_phase", phase, p);
    endtask

    initial begin
        int ticks;
        bus.en   = 1'b1;
        bus.mode = 2'd0;
        reset    = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_an", bus.an, 4'hF);
        chk("rst_sseg", bus.sseg, 8'hFF);
        chk("rst_ft", bus.frame_tick, 1'b0);
        reset = 1'b0;
        count_to_tick("first_tick", ST);
        count_to_tick("tick_period", ST);
        repeat (40) @(negedge clk);

        bus.mode = 2'd1;
        repeat (45) @(negedge clk);
        bus.mode = 2'd2;
        repeat (80) @(negedge clk);

        wait_phase(5);
        bus.en = 1'b0;
        ticks  = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.frame_tick) ticks++;
        end
        chk("freeze_ticks", ticks, 0);
        bus.en = 1'b1;
        count_to_tick("resume_tick", 3);

        bus.mode = 2'd1;
        repeat (3) @(negedge clk);
        wait_phase(7);
        bus.mode = 2'd2;
        @(negedge clk);
        chk("mc_ft", bus.frame_tick, 1'b0);
        chk("mc_mode", bus.mode_state, 2'd2);
        count_to_tick("mc_next_tick", ST);

        bus.mode = 2'd3;
        repeat (2) @(negedge clk);
        chk("blank_an", bus.an, 4'hF);
        chk("blank_sseg", bus.sseg, 8'hFF);

        bus.mode = 2'd2;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_an", bus.an, 4'hF);
        chk("mid_rst_sseg", bus.sseg, 8'hFF);
        chk("mid_rst_ft", bus.frame_tick, 1'b0);
        reset = 1'b0;
        count_to_tick("post_rst_tick", ST);

        repeat (500) begin
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) bus.mode = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/heartbeat_anim.md
# heartbeat_anim

Parametrised seven-segment animation engine, next generation of the 4-digit heartbeat display driver. It drives N_DIGITS multiplexed, common-anode digits and supports three selectable animations (heartbeat, sweep, bounce) plus blank. It has a run/freeze enable and a per-step strobe for pacing other logic. It sits directly behind the board's `an`/`sseg` pins.

## Interface
- N_DIGITS, 4: digit count; must be even, 2..8.
- STEP_TICKS, 10_000_000: clocks per animation step (100 ms at 100 MHz); ≥2.
- REFRESH_DIV, 50_000: clocks per digit in the multiplex scan; ≥1.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  1 = animation advances; 0 = freeze step timer and position; scanning continues.
- mode  in  2  0 heartbeat, 1 sweep, 2 bounce, 3 blank.
- an  out  N_DIGITS  anode enables, active-low, one-hot-low while scanning.
- sseg  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- frame_tick  out  1  one-cycle pulse on every animation step.

## Operation
- Registers:
  - ref_cnt: 0..REFRESH_DIV-1.
  - sel: 0..N_DIGITS-1. Digit 0 is rightmost.
  - step_cnt: 0..STEP_TICKS-1.
  - pos: 0..N_DIGITS-1.
  - dir: UP/DOWN.
  - mode_q.
  - Registered outputs an, sseg, frame_tick.
- Scan: ref_cnt free-runs. On ref_cnt==REFRESH_DIV-1 it wraps to 0 and sel advances (N_DIGITS-1 wraps to 0). This ignores en.
- Step: when en=1, step_cnt increments. On step_cnt==STEP_TICKS-1 it wraps to 0, pos/dir advance per mode, and frame_tick<=1. Otherwise frame_tick<=0.
- Mode FSM, step rules. Start values are used at reset and on every mode change.
  - HEARTBEAT (0): P=N_DIGITS/2. pos ping-pongs 0→P-1→0 without repeating endpoints; dir flips at the ends. P=1 means pos stays 0. Start: pos=0, dir=UP.
  - SWEEP (1): pos N-1, N-2, …, 0, then wraps to N-1. Start: pos=N-1.
  - BOUNCE (2): pos ping-pongs N-1→0→N-1 without repeating endpoints. Start: pos=N-1, dir=DOWN.
  - BLANK (3): pos held.
- Mode change: on any edge where mode≠mode_q:
  - mode_q<=mode, pos/dir load the start values, step_cnt<=0, frame_tick<=0.
  - This overrides a coincident step terminal count and applies regardless of en.
- Pattern for digit sel (8'hFF if not listed):
  - HEARTBEAT: digit N/2+pos shows f,e = 8'hCF; digit N/2-1-pos shows b,c = 8'hF9.
  - SWEEP: digit pos shows g = 8'hBF.
  - BOUNCE: digit pos shows c,d,e,g = 8'hA3.
  - BLANK: an=all 1s, sseg=8'hFF.
- Output stage: an<=~(1<<sel) (except BLANK), sseg<=pattern(sel, pos, mode_q).

## Timing
- Reset values on the edge with reset=1:
  - an=all 1s, sseg=8'hFF, frame_tick=0.
  - ref_cnt=0, sel=0, step_cnt=0.
  - mode_q=mode, pos/dir = start values of mode.
- Reset mid-operation: same values on the next edge. No partial state survives.
- First frame_tick comes at the STEP_TICKS-th rising edge after reset deasserts, then every STEP_TICKS clocks while en=1.
- en low: step_cnt holds and frame_tick stays 0. On re-enable, counting resumes from the held value, so no step is lost or duplicated.
- Latency: pos/sel change → an/sseg one cycle later. frame_tick is in the same cycle as the new pos.
- Each digit is enabled for exactly REFRESH_DIV consecutive cycles per scan. Scan period = N_DIGITS·REFRESH_DIV.
- Exactly one an bit is low at any time outside reset/BLANK.

## Test plan
All scenarios use N_DIGITS=4, STEP_TICKS=8, REFRESH_DIV=2.
1. Reset held 5 cycles, then released with mode=0:
   - During reset: an=4'hF, sseg=8'hFF, frame_tick=0.
   - frame_tick first high at edge 8 after release, then every 8 clocks.
   - an sequence 1110,1101,1011,0111, each held 2 cycles.
2. Heartbeat, mode=0:
   - pos=0: digit2 shows 8'hCF, digit1 shows 8'hF9, digits 0 and 3 show 8'hFF.
   - After a frame_tick: pos=1, digit3 shows CF, digit0 shows F9.
   - Over 4 steps, pos sequence is 0,1,0,1.
3. Sweep and bounce:
   - mode=1: lit digit (8'hBF) goes 3,2,1,0,3 on successive ticks.
   - mode=2: lit digit (8'hA3) goes 3,2,1,0,1,2,3,2.
4. Freeze: drop en for 20 cycles at step_cnt=5.
   - No frame_tick, and pos unchanged; scanning continues.
   - After en returns, the next frame_tick comes exactly 3 cycles later.
5. Mode change on the terminal-count cycle: switch mode 1→2 on the cycle where step_cnt==7.
   - frame_tick stays 0, pos=3, dir=DOWN.
   - The next tick comes 8 cycles later.
6. Blank and reset mid-run:
   - mode=3 gives an=4'hF and sseg=8'hFF one cycle after mode_q updates.
   - Reset asserted mid-bounce returns every output and counter to its reset value on the next edge.
